// File: rtl/serdiv_arbiter.sv
// Shares one serial divider among NR_REQ requesters with a single outstanding operation.
// Define SERDIV_ARB_RR_EN for round-robin grant; otherwise the lowest eligible index wins.
module serdiv_arbiter #(
  parameter int unsigned NR_REQ        = 2,
  parameter int unsigned WIDTH         = 64,
  // Matches ariane_pkg::TRANS_ID_BITS so the block builds without that package.
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NR_REQ-1:0]                        req_vld_i,
  output logic [NR_REQ-1:0]                        req_rdy_o,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]     req_id_i,
  input  logic [NR_REQ-1:0][WIDTH-1:0]             req_op_a_i,
  input  logic [NR_REQ-1:0][WIDTH-1:0]             req_op_b_i,
  input  logic [NR_REQ-1:0][1:0]                   req_opcode_i,
  input  logic [NR_REQ-1:0]                        req_flush_i,
  output logic [NR_REQ-1:0]                        resp_vld_o,
  input  logic [NR_REQ-1:0]                        resp_rdy_i,
  output logic [TRANS_ID_BITS-1:0]                 resp_id_o,
  output logic [WIDTH-1:0]                         resp_res_o,
  output logic                                     div_in_vld_o,
  output logic [TRANS_ID_BITS-1:0]                 div_id_o,
  output logic [WIDTH-1:0]                         div_op_a_o,
  output logic [WIDTH-1:0]                         div_op_b_o,
  output logic [1:0]                               div_opcode_o,
  input  logic                                     div_in_rdy_i,
  output logic                                     div_flush_o,
  input  logic                                     div_out_vld_i,
  input  logic [TRANS_ID_BITS-1:0]                 div_id_i,
  input  logic [WIDTH-1:0]                         div_res_i,
  output logic                                     div_out_rdy_o
);

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;

  state_e                   r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_owner;
  logic                     r_rdy_q;
  logic [TRANS_ID_BITS-1:0] r_id;
  logic [WIDTH-1:0]         r_op_a, r_op_b;
  logic [1:0]               r_opcode;

  logic [NR_REQ-1:0]        w_elig;
  logic                     w_gnt_vld;
  logic [IDX_W-1:0]         w_gnt_idx;
  logic                     w_own_flush;

  assign w_elig      = req_vld_i & ~req_flush_i;
  assign w_own_flush = req_flush_i[r_owner];

`ifdef SERDIV_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;
  logic             w_resp_done;

  assign w_resp_done = (r_state == BUSY) && !w_own_flush && div_out_vld_i && resp_rdy_i[r_owner];

  // Lowest eligible overall is the wrap-around fallback; lowest at/above r_ptr overrides it.
  always_comb begin
    w_gnt_vld = |w_elig;
    w_gnt_idx = '0;
    for (int unsigned i = NR_REQ; i > 0; i--) begin
      if (w_elig[i-1]) w_gnt_idx = IDX_W'(i-1);
    end
    for (int unsigned i = NR_REQ; i > 0; i--) begin
      if (w_elig[i-1] && ((i-1) >= 32'(r_ptr))) w_gnt_idx = IDX_W'(i-1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_resp_done) begin
      r_ptr <= (r_owner == IDX_W'(NR_REQ-1)) ? '0 : r_owner + 1'b1;
    end
  end
`else
  always_comb begin
    w_gnt_vld = |w_elig;
    w_gnt_idx = '0;
    for (int unsigned i = NR_REQ; i > 0; i--) begin
      if (w_elig[i-1]) w_gnt_idx = IDX_W'(i-1);
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    req_rdy_o     = '0;
    resp_vld_o    = '0;
    resp_id_o     = '0;
    resp_res_o    = '0;
    div_in_vld_o  = 1'b0;
    div_flush_o   = 1'b0;
    div_out_rdy_o = 1'b0;
    case (r_state)
      IDLE: begin
        // rst_ni gating keeps req_rdy_o low while reset is held.
        if (w_gnt_vld && rst_ni) begin
          req_rdy_o[w_gnt_idx] = 1'b1;
          w_state_nxt          = ISSUE;
        end
      end
      ISSUE: begin
        if (w_own_flush) begin
          div_flush_o = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_rdy_q) begin
          div_in_vld_o = 1'b1;
          w_state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (w_own_flush) begin
          div_flush_o = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          resp_vld_o[r_owner] = div_out_vld_i;
          resp_id_o           = div_id_i;
          resp_res_o          = div_res_i;
          div_out_rdy_o       = resp_rdy_i[r_owner];
          if (div_out_vld_i && resp_rdy_i[r_owner]) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rdy_q  <= 1'b0;
      r_id     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_opcode <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy_q <= div_in_rdy_i;
      if (r_state == IDLE && w_gnt_vld) begin
        r_owner  <= w_gnt_idx;
        r_id     <= req_id_i[w_gnt_idx];
        r_op_a   <= req_op_a_i[w_gnt_idx];
        r_op_b   <= req_op_b_i[w_gnt_idx];
        r_opcode <= req_opcode_i[w_gnt_idx];
      end
    end
  end

  assign div_id_o     = r_id;
  assign div_op_a_o   = r_op_a;
  assign div_op_b_o   = r_op_b;
  assign div_opcode_o = r_opcode;

endmodule

// File: tb/tb_serdiv_arbiter.sv
// Directed bench for serdiv_arbiter with a small behavioural divider stand-in.
module tb_serdiv_arbiter;

  localparam int unsigned NR  = 2;
  localparam int unsigned W   = 64;
  localparam int unsigned IDB = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]           req_vld, req_rdy, req_flush, resp_vld, resp_rdy;
  logic [NR-1:0][IDB-1:0]  req_id;
  logic [NR-1:0][W-1:0]    req_op_a, req_op_b;
  logic [NR-1:0][1:0]      req_opcode;
  logic [IDB-1:0]          resp_id, div_id_o, div_id_i;
  logic [W-1:0]            resp_res, div_op_a, div_op_b, div_res_i;
  logic [1:0]              div_opcode;
  logic                    div_in_vld, div_in_rdy, div_flush, div_out_vld, div_out_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  serdiv_arbiter #(.NR_REQ(NR), .WIDTH(W), .TRANS_ID_BITS(IDB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_id_i(req_id),
    .req_op_a_i(req_op_a), .req_op_b_i(req_op_b), .req_opcode_i(req_opcode),
    .req_flush_i(req_flush), .resp_vld_o(resp_vld), .resp_rdy_i(resp_rdy),
    .resp_id_o(resp_id), .resp_res_o(resp_res),
    .div_in_vld_o(div_in_vld), .div_id_o(div_id_o), .div_op_a_o(div_op_a),
    .div_op_b_o(div_op_b), .div_opcode_o(div_opcode), .div_in_rdy_i(div_in_rdy),
    .div_flush_o(div_flush), .div_out_vld_i(div_out_vld), .div_id_i(div_id_i),
    .div_res_i(div_res_i), .div_out_rdy_o(div_out_rdy)
  );

  // Divider stand-in: accepts one op, result ready 4 cycles later, held until taken.
  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a / b;
      2'd1:    return W'($signed(a) / $signed(b));
      2'd2:    return a % b;
      default: return W'($signed(a) % $signed(b));
    endcase
  endfunction

  logic           dv_busy;
  logic [2:0]     dv_cnt;
  logic [W-1:0]   dv_res;
  logic [IDB-1:0] dv_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_busy <= 1'b0; dv_cnt <= '0; dv_res <= '0; dv_id <= '0;
    end else if (div_flush) begin
      dv_busy <= 1'b0;
    end else if (!dv_busy && div_in_vld) begin
      dv_busy <= 1'b1; dv_cnt <= 3'd3;
      dv_res  <= ref_div(div_opcode, div_op_a, div_op_b);
      dv_id   <= div_id_o;
    end else if (dv_busy && dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1'b1;
    end else if (dv_busy && div_out_rdy) begin
      dv_busy <= 1'b0;
    end
  end

  assign div_out_vld = dv_busy && (dv_cnt == 0);
  assign div_in_rdy  = !dv_busy;
  assign div_res_i   = dv_res;
  assign div_id_i    = dv_id;

  task automatic clear_inputs();
    req_vld = '0; req_flush = '0; resp_rdy = '1;
    req_id = '0; req_op_a = '0; req_op_b = '0; req_opcode = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_gnt(output bit ok, output logic [NR-1:0] g);
    ok = 1'b0; g = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_rdy != 0) begin ok = 1'b1; g = req_rdy; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_resp(output bit ok, output logic [NR-1:0] vld, output logic [W-1:0] res,
                           output logic [IDB-1:0] id, output int flushes, output int issues);
    ok = 1'b0; vld = '0; res = '0; id = '0; flushes = 0; issues = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_flush)  flushes++;
      if (div_in_vld) issues++;
      if (resp_vld != 0) begin ok = 1'b1; vld = resp_vld; res = resp_res; id = resp_id; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req_vld = '1;
    @(negedge clk);
    n_tests++;
    if (req_rdy !== 2'b00 || resp_vld !== 2'b00) begin
      n_fail++; $display("FAIL reset_hs: req_rdy=%b resp_vld=%b expected 00/00", req_rdy, resp_vld);
    end
    n_tests++;
    if ({div_in_vld, div_flush, div_out_rdy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_div: in_vld/flush/out_rdy=%b expected 000", {div_in_vld, div_flush, div_out_rdy});
    end
    n_tests++;
    if (div_op_a !== '0 || div_op_b !== '0 || div_id_o !== '0 || div_opcode !== '0) begin
      n_fail++; $display("FAIL reset_issue_reg: op_a=%0h op_b=%0h id=%0h opc=%0h expected 0", div_op_a, div_op_b, div_id_o, div_opcode);
    end
    rst_n = 1'b1;
    req_vld = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; logic [NR-1:0] vld; logic [W-1:0] res; logic [IDB-1:0] id; int fl, is;
    apply_reset();
    req_id[0] = 3'd3; req_op_a[0] = 64'd100; req_op_b[0] = 64'd7; req_opcode[0] = 2'd0;
    req_vld = 2'b01;
    #1;
    n_tests++;
    if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL single_accept: req_rdy=%b expected 01", req_rdy); end
    @(negedge clk);
    req_vld = 2'b00;
    #1;
    n_tests++;
    if (req_rdy !== 2'b00 || div_in_vld !== 1'b1) begin
      n_fail++; $display("FAIL single_issue: req_rdy=%b div_in_vld=%b expected 00/1", req_rdy, div_in_vld);
    end
    n_tests++;
    if (div_op_a !== 64'd100 || div_op_b !== 64'd7 || div_id_o !== 3'd3 || div_opcode !== 2'd0) begin
      n_fail++; $display("FAIL single_payload: a=%0d b=%0d id=%0d opc=%0d expected 100/7/3/0", div_op_a, div_op_b, div_id_o, div_opcode);
    end
    wait_resp(ok, vld, res, id, fl, is);
    n_tests++;
    if (!ok || vld !== 2'b01 || res !== 64'd14 || id !== 3'd3) begin
      n_fail++; $display("FAIL single_resp: ok=%0d vld=%b res=%0d id=%0d expected 1/01/14/3", ok, vld, res, id);
    end
    n_tests++;
    if (is !== 0) begin n_fail++; $display("FAIL single_one_pulse: extra issue pulses=%0d expected 0", is); end
    @(negedge clk);
    n_tests++;
    if (resp_vld !== 2'b00) begin n_fail++; $display("FAIL single_resp_drop: resp_vld=%b expected 00", resp_vld); end
  endtask

  task automatic test_arbitration();
    bit ok; logic [NR-1:0] g, vld; logic [W-1:0] res, exp_res; logic [IDB-1:0] id; int fl, is;
    logic [NR-1:0] exp_g [4];
`ifdef SERDIV_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    apply_reset();
    req_id[0] = 3'd1; req_op_a[0] = 64'd50; req_op_b[0] = 64'd5;
    req_id[1] = 3'd2; req_op_a[1] = 64'd63; req_op_b[1] = 64'd7;
    req_vld = 2'b11;
    for (int op = 0; op < 4; op++) begin
      wait_gnt(ok, g);
      n_tests++;
      if (!ok || g !== exp_g[op]) begin
        n_fail++; $display("FAIL arb_grant%0d: req_rdy=%b expected %b", op, g, exp_g[op]);
      end
      @(negedge clk);
      wait_resp(ok, vld, res, id, fl, is);
      exp_res = (g == 2'b01) ? 64'd10 : 64'd9;
      n_tests++;
      if (!ok || vld !== g || res !== exp_res) begin
        n_fail++; $display("FAIL arb_resp%0d: vld=%b res=%0d expected %b/%0d", op, vld, res, g, exp_res);
      end
      @(negedge clk);
    end
    req_vld = 2'b00;
  endtask

  task automatic test_flush_busy();
    bit ok; logic [NR-1:0] g, vld; logic [W-1:0] res; logic [IDB-1:0] id; int fl, is;
    logic [NR-1:0] exp_after;
`ifdef SERDIV_ARB_RR_EN
    exp_after = 2'b10;
`else
    exp_after = 2'b01;
`endif
    apply_reset();
    req_id[0] = 3'd1; req_op_a[0] = 64'd20; req_op_b[0] = 64'd4;
    req_id[1] = 3'd5; req_op_a[1] = 64'd30; req_op_b[1] = 64'd3;
    req_vld = 2'b01;
    wait_gnt(ok, g);
    @(negedge clk);
    req_vld = 2'b00;
    wait_resp(ok, vld, res, id, fl, is);
    @(negedge clk);
    req_vld = 2'b10;
    wait_gnt(ok, g);
    n_tests++;
    if (!ok || g !== 2'b10) begin n_fail++; $display("FAIL flush_grant: req_rdy=%b expected 10", g); end
    @(negedge clk);
    req_vld = 2'b00;
    @(negedge clk);
    req_flush = 2'b10;
    #1;
    n_tests++;
    if (div_flush !== 1'b1 || resp_vld !== 2'b00 || div_in_vld !== 1'b0) begin
      n_fail++; $display("FAIL flush_pulse: div_flush=%b resp_vld=%b div_in_vld=%b expected 1/00/0", div_flush, resp_vld, div_in_vld);
    end
    @(negedge clk);
    req_flush = 2'b00;
    req_vld = 2'b11;
    #1;
    n_tests++;
    if (div_flush !== 1'b0 || resp_vld !== 2'b00) begin
      n_fail++; $display("FAIL flush_one_cycle: div_flush=%b resp_vld=%b expected 0/00", div_flush, resp_vld);
    end
    n_tests++;
    if (req_rdy !== exp_after) begin
      n_fail++; $display("FAIL flush_ptr_kept: req_rdy=%b expected %b", req_rdy, exp_after);
    end
    @(negedge clk);
    req_vld = 2'b00;
    wait_resp(ok, vld, res, id, fl, is);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok; logic [NR-1:0] g, vld; logic [W-1:0] res; logic [IDB-1:0] id; int fl, is;
    apply_reset();
    resp_rdy = 2'b10;
    req_id[0] = 3'd6; req_op_a[0] = 64'd81; req_op_b[0] = 64'd9;
    req_vld = 2'b01;
    wait_gnt(ok, g);
    @(negedge clk);
    req_vld = 2'b00;
    wait_resp(ok, vld, res, id, fl, is);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_resp_timeout: got no resp_vld expected 01"); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (resp_vld !== 2'b01 || div_out_rdy !== 1'b0 || resp_res !== 64'd9) begin
        n_fail++; $display("FAIL bp_hold%0d: vld=%b out_rdy=%b res=%0d expected 01/0/9", k, resp_vld, div_out_rdy, resp_res);
      end
      @(negedge clk);
    end
    resp_rdy = 2'b11;
    #1;
    n_tests++;
    if (div_out_rdy !== 1'b1 || resp_vld !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: out_rdy=%b vld=%b expected 1/01", div_out_rdy, resp_vld);
    end
    @(negedge clk);
    n_tests++;
    if (resp_vld !== 2'b00) begin n_fail++; $display("FAIL bp_complete: resp_vld=%b expected 00", resp_vld); end
  endtask

  task automatic test_reset_busy();
    bit ok; logic [NR-1:0] g, vld; logic [W-1:0] res; logic [IDB-1:0] id; int fl, is;
    apply_reset();
    req_id[0] = 3'd2; req_op_a[0] = 64'd100; req_op_b[0] = 64'd7;
    req_vld = 2'b01;
    wait_gnt(ok, g);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_rdy, resp_vld, div_in_vld, div_flush, div_out_rdy} !== 7'b0) begin
      n_fail++; $display("FAIL rst_busy_outputs: rdy=%b vld=%b in_vld=%b flush=%b out_rdy=%b expected all 0",
                         req_rdy, resp_vld, div_in_vld, div_flush, div_out_rdy);
    end
    repeat (2) @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    req_id[1] = 3'd4; req_op_a[1] = 64'hFFFF_FFFF_FFFF_FFEC; req_op_b[1] = 64'd3; req_opcode[1] = 2'd1;
    req_vld = 2'b10;
    wait_gnt(ok, g);
    n_tests++;
    if (!ok || g !== 2'b10) begin n_fail++; $display("FAIL rst_fresh_grant: req_rdy=%b expected 10", g); end
    @(negedge clk);
    req_vld = 2'b00;
    wait_resp(ok, vld, res, id, fl, is);
    n_tests++;
    if (!ok || vld !== 2'b10 || res !== 64'hFFFF_FFFF_FFFF_FFFA || id !== 3'd4) begin
      n_fail++; $display("FAIL rst_fresh_resp: vld=%b res=%0h id=%0d expected 10/fffffffffffffffa/4", vld, res, id);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_other();
    bit ok, fl0; logic [NR-1:0] g, vld; logic [W-1:0] res; logic [IDB-1:0] id; int fl, is;
    apply_reset();
    req_id[1] = 3'd7; req_op_a[1] = 64'd90; req_op_b[1] = 64'd9;
    req_vld = 2'b10;
    wait_gnt(ok, g);
    n_tests++;
    if (!ok || g !== 2'b10) begin n_fail++; $display("FAIL other_grant: req_rdy=%b expected 10", g); end
    @(negedge clk);
    req_vld = 2'b01;
    req_flush = 2'b01;
    #1;
    fl0 = div_flush;
    wait_resp(ok, vld, res, id, fl, is);
    n_tests++;
    if (!ok || vld !== 2'b10 || res !== 64'd10 || id !== 3'd7) begin
      n_fail++; $display("FAIL other_resp: vld=%b res=%0d id=%0d expected 10/10/7", vld, res, id);
    end
    n_tests++;
    if (fl0 !== 1'b0 || fl !== 0) begin
      n_fail++; $display("FAIL other_no_flush: flush cycles=%0d expected 0", fl + int'(fl0));
    end
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_flush_busy();
    test_backpressure();
    test_reset_busy();
    test_flush_other();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
